// File: rtl/gate_reduce_unit.sv
// gate_reduce_unit: bitwise gate function (AND/NAND/OR/NOR/XOR/XNOR) reduced over NIN operands
// and accumulated across a multi-beat packet. Optional out_parity port: define GATE_REDUCE_PARITY_EN.
module gate_reduce_unit #(
    parameter int WIDTH = 4,
    parameter int NIN   = 3,
    parameter int CNTW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NIN*WIDTH-1:0]  in_data,
    input  logic [2:0]            in_op,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [CNTW-1:0]       out_beats
`ifdef GATE_REDUCE_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    localparam logic [1:0]      BASE_AND = 2'd0;
    localparam logic [1:0]      BASE_OR  = 2'd1;
    localparam logic [1:0]      BASE_XOR = 2'd2;
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

    function automatic logic [1:0] base_of(input logic [2:0] op);
        logic [1:0] b;
        case (op)
            3'd2, 3'd3: b = BASE_OR;
            3'd4, 3'd5: b = BASE_XOR;
            default:    b = BASE_AND;   // 0, 1 and the reserved 6/7 (NAND)
        endcase
        return b;
    endfunction

    function automatic logic inv_of(input logic [2:0] op);
        logic v;
        case (op)
            3'd0, 3'd2, 3'd4: v = 1'b0;
            default:          v = 1'b1;
        endcase
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0]       base);
        logic [WIDTH-1:0] r;
        case (base)
            BASE_OR:  r = a | b;
            BASE_XOR: r = a ^ b;
            default:  r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] reduce(input logic [NIN*WIDTH-1:0] data,
                                                input logic [1:0]           base);
        logic [WIDTH-1:0] r;
        r = data[0 +: WIDTH];
        for (int k = 1; k < NIN; k++) begin
            r = combine(r, data[k*WIDTH +: WIDTH], base);
        end
        return r;
    endfunction

    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [1:0]       base_r, base_nxt_s;
    logic             inv_r, inv_nxt_s;
    logic [WIDTH-1:0] acc_r, acc_nxt_s;
    logic [CNTW-1:0]  cnt_r, cnt_nxt_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [CNTW-1:0]  out_beats_r;
    logic             out_parity_r;

    logic             accept_s;
    logic             load_s;
    logic [1:0]       beat_base_s;
    logic             beat_inv_s;
    logic [WIDTH-1:0] beat_red_s;
    logic [WIDTH-1:0] merged_s;
    logic [WIDTH-1:0] result_s;
    logic [CNTW-1:0]  cnt_sat_s;
    logic [CNTW-1:0]  result_beats_s;

    assign in_ready  = !out_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_beats = out_beats_r;
`ifdef GATE_REDUCE_PARITY_EN
    assign out_parity = out_parity_r;
`endif

    // Datapath: the function is taken from in_op on the first beat, from the latched copy afterwards.
    always_comb begin
        beat_base_s    = base_of(in_op);
        beat_inv_s     = inv_of(in_op);
        cnt_sat_s      = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
        result_beats_s = CNT_ONE;
        if (state_r == ST_ACC) begin
            beat_base_s    = base_r;
            beat_inv_s     = inv_r;
            result_beats_s = cnt_sat_s;
        end else begin
            result_beats_s = CNT_ONE;
        end
        beat_red_s = reduce(in_data, beat_base_s);
        if (state_r == ST_ACC) begin
            merged_s = combine(acc_r, beat_red_s, base_r);
        end else begin
            merged_s = beat_red_s;
        end
        // Inversion is applied only to the final value, never to the running accumulation.
        result_s = beat_inv_s ? ~merged_s : merged_s;
    end

    // Next-state and accumulator update.
    always_comb begin
        state_nxt_s = state_r;
        base_nxt_s  = base_r;
        inv_nxt_s   = inv_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && in_last) begin
                    load_s = 1'b1;
                end else if (accept_s) begin
                    state_nxt_s = ST_ACC;
                    base_nxt_s  = beat_base_s;
                    inv_nxt_s   = beat_inv_s;
                    acc_nxt_s   = beat_red_s;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (accept_s && in_last) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                    acc_nxt_s   = {WIDTH{1'b0}};
                    cnt_nxt_s   = {CNTW{1'b0}};
                end else if (accept_s) begin
                    acc_nxt_s = merged_s;
                    cnt_nxt_s = cnt_sat_s;
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Packet state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            base_r  <= BASE_AND;
            inv_r   <= 1'b0;
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNTW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            base_r  <= base_nxt_s;
            inv_r   <= inv_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Output register: a new result overrides a same-cycle take; otherwise hold until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
            out_beats_r  <= {CNTW{1'b0}};
            out_parity_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= result_s;
            out_beats_r  <= result_beats_s;
            out_parity_r <= parity_of(result_s);
        end else if (out_valid_r && out_ready) begin
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

`ifndef GATE_REDUCE_PARITY_EN
    logic unused_parity_s;
    assign unused_parity_s = out_parity_r;
`endif

endmodule
